// File: rtl/mux_rr4.sv
// Four-channel round-robin merging mux feeding one registered valid/ready output stream.
// Optional build macro MUX_RR4_PRIO0_EN gives channel 0 absolute priority over channels 1-3.
//
// Handshake: a word moves across any interface on a rising edge where its
// valid (m_req_i / m_valid) and ready (m_ack_i / m_ready) are both high.
// m_ack_i is combinational and only asserts for the single channel loaded that cycle.
module mux_rr4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m_in_0,
  input  logic [WIDTH-1:0] m_in_1,
  input  logic [WIDTH-1:0] m_in_2,
  input  logic [WIDTH-1:0] m_in_3,
  input  logic             m_req_0,
  input  logic             m_req_1,
  input  logic             m_req_2,
  input  logic             m_req_3,
  output logic             m_ack_0,
  output logic             m_ack_1,
  output logic             m_ack_2,
  output logic             m_ack_3,
  output logic [WIDTH-1:0] m_out,
  output logic [1:0]       m_sel,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;

  logic [3:0]       req;
  logic             any_req;
  logic             load;
  logic [1:0]       grant;
  logic [1:0]       ptr_next;
  logic             found;
  logic [1:0]       idx;
  logic [3:0]       ack_vec;
  logic [WIDTH-1:0] grant_data;

  assign req     = {m_req_3, m_req_2, m_req_1, m_req_0};
  assign any_req = |req;
  assign load    = any_req & ((state_q == EMPTY) | m_ready);

  // First requester at or after ptr, modulo 4.
  always_comb begin
    found    = 1'b0;
    grant    = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    ptr_next = grant + 2'd1;
`ifdef MUX_RR4_PRIO0_EN
    // Channel 0 preempts the rotation and leaves the pointer where it was.
    if (req[0]) begin
      grant    = 2'd0;
      ptr_next = ptr_q;
    end
`endif
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = m_in_0;
      2'd1:    grant_data = m_in_1;
      2'd2:    grant_data = m_in_2;
      default: grant_data = m_in_3;
    endcase
  end

  // Gate with rst_n so no requester sees a grant while reset is held.
  assign ack_vec = (load && rst_n) ? (4'b0001 << grant) : 4'b0000;
  assign m_ack_0 = ack_vec[0];
  assign m_ack_1 = ack_vec[1];
  assign m_ack_2 = ack_vec[2];
  assign m_ack_3 = ack_vec[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      out_q   <= '0;
      sel_q   <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_q <= FULL;
            out_q   <= grant_data;
            sel_q   <= grant;
            ptr_q   <= ptr_next;
          end
        end
        FULL: begin
          if (load) begin
            out_q <= grant_data;
            sel_q <= grant;
            ptr_q <= ptr_next;
          end else if (m_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign m_valid = (state_q == FULL);
  assign m_out   = out_q;
  assign m_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr4.sv
// Randomized scoreboard bench for mux_rr4; reference model is a plain arbitration function over a request array.
module tb_mux_rr4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] m_in_0, m_in_1, m_in_2, m_in_3;
  logic         m_req_0, m_req_1, m_req_2, m_req_3;
  logic         m_ack_0, m_ack_1, m_ack_2, m_ack_3;
  logic [W-1:0] m_out;
  logic [1:0]   m_sel;
  logic         m_valid;
  logic         m_ready;

  mux_rr4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_in_0(m_in_0), .m_in_1(m_in_1), .m_in_2(m_in_2), .m_in_3(m_in_3),
    .m_req_0(m_req_0), .m_req_1(m_req_1), .m_req_2(m_req_2), .m_req_3(m_req_3),
    .m_ack_0(m_ack_0), .m_ack_1(m_ack_1), .m_ack_2(m_ack_2), .m_ack_3(m_ack_3),
    .m_out(m_out), .m_sel(m_sel), .m_valid(m_valid), .m_ready(m_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W+1:0] exp_q[$];

  bit           req_b[4];
  logic [W-1:0] din[4];
  int           mptr = 0;
  bit           mfull = 0;
  int           last_g = -1;
  bit           allow_new = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    m_req_0 = req_b[0]; m_req_1 = req_b[1]; m_req_2 = req_b[2]; m_req_3 = req_b[3];
    m_in_0  = din[0];   m_in_1  = din[1];   m_in_2  = din[2];   m_in_3  = din[3];
  endtask

  // Reference arbitration: first requester scanning from the model pointer.
  function automatic int model_grant();
`ifdef MUX_RR4_PRIO0_EN
    if (req_b[0]) return 0;
`endif
    for (int k = 0; k < 4; k++)
      if (req_b[(mptr + k) % 4]) return (mptr + k) % 4;
    return -1;
  endfunction

  task automatic step(input bit rnd, input bit rdy);
    int         g;
    bit         load;
    logic [3:0] exp_ack;
    logic [3:0] act_ack;
    @(negedge clk);
    if (rnd) begin
      if (last_g >= 0) begin
        if (allow_new && $urandom_range(1, 0) == 1) din[last_g] = W'($urandom);
        else req_b[last_g] = 0;
      end
      if (allow_new)
        for (int i = 0; i < 4; i++)
          if (!req_b[i] && $urandom_range(2, 0) == 0) begin
            req_b[i] = 1;
            din[i]   = W'($urandom);
          end
    end
    m_ready = rdy;
    drive();
    #1;
    check("m_valid", 32'(m_valid), 32'(mfull));
    g       = model_grant();
    load    = (g >= 0) && (!mfull || rdy);
    exp_ack = load ? 4'(1 << g) : 4'b0000;
    act_ack = {m_ack_3, m_ack_2, m_ack_1, m_ack_0};
    check("acks", 32'(act_ack), 32'(exp_ack));
    if (load) begin
      exp_q.push_back({2'(g), din[g]});
`ifdef MUX_RR4_PRIO0_EN
      if (g != 0) mptr = (g + 1) % 4;
`else
      mptr = (g + 1) % 4;
`endif
      mfull  = 1;
      last_g = g;
    end else begin
      last_g = -1;
      if (rdy) mfull = 0;
    end
  endtask

  // scoreboard monitor: pop on every accepted output word
  always @(negedge clk) begin
    logic [W+1:0] e;
    #2;
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got sel %0d data %0h expected none", m_sel, m_out);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(m_out), 32'(e[W-1:0]));
        check("out_sel", 32'(m_sel), 32'(e[W+1:W]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_b[i] = 1;
      din[i]   = W'(8'h10 + i);
    end
    drive();
    #12;
    check("rst_acks", 32'({m_ack_3, m_ack_2, m_ack_1, m_ack_0}), 32'h0);
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_out", 32'(m_out), 32'h0);
    check("rst_sel", 32'(m_sel), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // rotation with all four held, then backpressure, then release
    for (int i = 0; i < 8; i++) step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 0);
    for (int i = 0; i < 4; i++) step(0, 1);

    for (int i = 0; i < 500; i++) step(1, $urandom_range(3, 0) != 0);

    // reset while a word sits in the output register
    guard = 0;
    while (!mfull && guard < 50) begin
      step(1, 1);
      guard++;
    end
    check("pre_reset_full", 32'(mfull), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 32'h0);
    check("midrst_acks", 32'({m_ack_3, m_ack_2, m_ack_1, m_ack_0}), 32'h0);
    exp_q.delete();
    mfull  = 0;
    mptr   = 0;
    last_g = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step(1, $urandom_range(3, 0) != 0);

    allow_new = 0;
    guard = 0;
    while ((mfull || req_b[0] || req_b[1] || req_b[2] || req_b[3]) && guard < 100) begin
      step(1, 1);
      guard++;
    end
    step(1, 1);
    @(negedge clk);
    #3;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
